// File: rtl/render_seq_pkg.sv
// render_seq_pkg: shared state encoding, default widths and watchdog width helper for render_seq_ctrl
package render_seq_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;
  localparam int FRAME_CNT_W_DEF = 16;
  localparam int DROP_CNT_W_DEF = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
  function automatic int wdt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/render_seq_ctrl_if.sv
// render_seq_ctrl_if: pass/swap handshake pulses between the render sequencer and its engines
interface render_seq_ctrl_if;
  logic vblank_start;
  logic start_render;
  logic clear_done;
  logic draw_done;
  logic clear_start;
  logic draw_start;
  logic swap_req;
  modport master (
    input  vblank_start, start_render, clear_done, draw_done,
    output clear_start, draw_start, swap_req
  );
  modport slave (
    output vblank_start, start_render, clear_done, draw_done,
    input  clear_start, draw_start, swap_req
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with clear, either wrapping or saturating at all-ones
module sat_counter #(
  parameter int W = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  // count up; hold at all-ones when saturating
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && !(SAT && &cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/render_seq_ctrl.sv
// render_seq_ctrl: per-frame clear/draw sequencer with VBLANK swap requests; RENDER_SEQ_WDT_EN adds a per-pass watchdog
module render_seq_ctrl
  import render_seq_pkg::*;
#(
  parameter int FRAME_CNT_W = FRAME_CNT_W_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
`ifdef RENDER_SEQ_WDT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                   clk_sys,
  input  logic                   srst,
  input  logic                   enable,
  render_seq_ctrl_if.master      bus,
  output logic                   render_idle,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  output logic                   overrun,
  output logic                   err_timeout
);
  state_t state, state_d;
  logic frame_ready, booted, go, done, swap, drop, wdt_hit;
  // next state plus swap/drop decisions; a pass start outranks a swap in the same cycle
  always_comb begin
    go = (state == IDLE) && enable && (bus.start_render || !booted);
    done = (state == DRAW) && bus.draw_done;
    state_d = (state == IDLE) ? (go ? CLEAR : IDLE)
            : (state == CLEAR) ? (bus.clear_done ? DRAW : wdt_hit ? IDLE : CLEAR)
            : ((bus.draw_done || wdt_hit) ? IDLE : DRAW);
    swap = bus.vblank_start && (state == IDLE) && frame_ready && !go;
    drop = bus.vblank_start && enable && !swap;
  end
  // state register and registered pulse outputs
  always_ff @(posedge clk_sys) begin
    if (srst) begin
      state <= IDLE;
      frame_ready <= 1'b0;
      booted <= 1'b0;
      bus.clear_start <= 1'b0;
      bus.draw_start <= 1'b0;
      bus.swap_req <= 1'b0;
      overrun <= 1'b0;
      render_idle <= 1'b1;
    end else begin
      state <= state_d;
      frame_ready <= done ? 1'b1 : swap ? 1'b0 : frame_ready;
      booted <= booted || go;
      bus.clear_start <= go;
      bus.draw_start <= (state == CLEAR) && bus.clear_done;
      bus.swap_req <= swap;
      overrun <= drop;
      render_idle <= (state_d == IDLE);
    end
  end
  sat_counter #(.W(FRAME_CNT_W), .SAT(1'b0)) u_frame_cnt (
    .clk(clk_sys), .rst(srst), .clr(1'b0), .inc(done), .cnt(frame_cnt)
  );
  sat_counter #(.W(DROP_CNT_W), .SAT(1'b1)) u_drop_cnt (
    .clk(clk_sys), .rst(srst), .clr(1'b0), .inc(drop), .cnt(drop_cnt)
  );
`ifdef RENDER_SEQ_WDT_EN
  localparam int WDT_W = wdt_w(TIMEOUT_CYCLES);
  logic [WDT_W-1:0] wdt;
  assign wdt_hit = (state != IDLE) && (wdt == WDT_W'(TIMEOUT_CYCLES - 1));
  // cycles spent in the current state, restarted on every state entry
  always_ff @(posedge clk_sys)
    wdt <= (srst || state_d != state) ? '0 : (state != IDLE) ? wdt + 1'b1 : wdt;
  // sticky timeout flag; a done pulse on the last cycle still completes the pass
  always_ff @(posedge clk_sys)
    err_timeout <= srst ? 1'b0 : err_timeout || (wdt_hit && state_d == IDLE && !done);
`else
  assign wdt_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule
